uart_io_arbiter: RTL and testbench

Shares one UART between two byte producers and buffers its receive path. Transmit: round-robin arbitration between requester A (core output) and requester B (debug monitor), sequencing the UART's `transmit` / `is_transmitting` handshake. Receive: queues `received` bytes in a small FIFO, flags overrun and counts framing errors. Sits between the core/debug logic and the UART instance.

---
 rtl/uart_io_arbiter_if.sv | 43 ++++
 rtl/uart_io_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_io_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_io_arbiter_if.sv
// uart_io_arbiter_if
//   Bundles the signals of uart_io_arbiter other than clk/rst. This covers the
//   two transmit requesters, the RX FIFO read port, the RX status outputs and
//   the UART instance pins.
//   modport slave  : the arbiter itself
//   modport master : the surrounding core/debug logic and UART
interface uart_io_arbiter_if;
   // transmit requesters
   logic       a_req;
   logic       b_req;
   logic [7:0] a_byte;
   logic [7:0] b_byte;
   logic       a_ack;
   logic       b_ack;
   // receive FIFO read port and status
   logic       rd_req;
   logic       rd_valid;
   logic [7:0] rd_byte;
   logic       clr;
   logic       rx_overrun;
   logic [7:0] rx_err_cnt;
   // UART pins
   logic       uart_transmit;
   logic [7:0] uart_tx_byte;
   logic       uart_is_transmitting;
   logic       uart_received;
   logic [7:0] uart_rx_byte;
   logic       uart_recv_error;

   modport slave (
      input  a_req, b_req, a_byte, b_byte, rd_req, clr,
             uart_is_transmitting, uart_received, uart_rx_byte, uart_recv_error,
      output a_ack, b_ack, rd_valid, rd_byte, rx_overrun, rx_err_cnt,
             uart_transmit, uart_tx_byte
   );

   modport master (
      output a_req, b_req, a_byte, b_byte, rd_req, clr,
             uart_is_transmitting, uart_received, uart_rx_byte, uart_recv_error,
      input  a_ack, b_ack, rd_valid, rd_byte, rx_overrun, rx_err_cnt,
             uart_transmit, uart_tx_byte
   );
endinterface

// File: rtl/uart_io_arbiter.sv
// uart_io_arbiter
//   Shares one UART between requester A (core) and requester B (debug).
//   TX: round-robin grant, then sequences the UART transmit/is_transmitting
//   handshake. If busy never appears, transmit is reissued after 4 cycles.
//   RX: buffers received bytes in a 2^RX_DEPTH_LOG2 FIFO. It also keeps a
//   sticky overrun flag and a saturating framing-error count.
// Ports
//   clk  master clock
//   rst  asynchronous active-high reset (the UART is reset alongside)
//   bus  uart_io_arbiter_if.slave: requesters, RX read port, status, UART pins
module uart_io_arbiter #(
   parameter int RX_DEPTH_LOG2 = 2
) (
   input  logic               clk,
   input  logic               rst,
   uart_io_arbiter_if.slave   bus
);
   localparam int AW    = RX_DEPTH_LOG2;
   localparam int DEPTH = 1 << AW;

   // ---------------- TX arbiter / handshake FSM ----------------
   typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, ACK} tx_state_t;

   tx_state_t  state, state_n;
   logic       grant_b, grant_b_n;   // current grant is B
   logic       last_b, last_b_n;     // last completed grant was B
   logic [1:0] tout, tout_n;
   logic [7:0] tx_byte, tx_byte_n;
   logic       transmit_q, a_ack_q, b_ack_q;

   always_comb begin
      state_n   = state;
      grant_b_n = grant_b;
      last_b_n  = last_b;
      tout_n    = tout;
      tx_byte_n = tx_byte;
      case (state)
         IDLE: begin
            if (bus.a_req || bus.b_req) begin
               // With both requesting, B wins only if A was served last.
               grant_b_n = bus.b_req && (!bus.a_req || !last_b);
               tx_byte_n = grant_b_n ? bus.b_byte : bus.a_byte;
               state_n   = START;
            end
         end
         START: begin
            tout_n  = 2'd0;
            state_n = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.uart_is_transmitting)
               state_n = WAIT_DONE;
            else if (tout == 2'd3)
               state_n = START;        // 4th idle cycle: reissue the same byte
            else
               tout_n = tout + 2'd1;
         end
         WAIT_DONE: begin
            if (!bus.uart_is_transmitting)
               state_n = ACK;
         end
         ACK: begin
            last_b_n = grant_b;
            state_n  = IDLE;           // a still-high req is only seen in IDLE
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from the next-state decode, so each output is high
   // exactly while the FSM sits in the matching state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant_b    <= 1'b0;
         last_b     <= 1'b1;           // makes A the first winner after reset
         tout       <= 2'd0;
         tx_byte    <= 8'd0;
         transmit_q <= 1'b0;
         a_ack_q    <= 1'b0;
         b_ack_q    <= 1'b0;
      end else begin
         state      <= state_n;
         grant_b    <= grant_b_n;
         last_b     <= last_b_n;
         tout       <= tout_n;
         tx_byte    <= tx_byte_n;
         transmit_q <= (state_n == START);
         a_ack_q    <= (state_n == ACK) && !grant_b_n;
         b_ack_q    <= (state_n == ACK) &&  grant_b_n;
      end
   end

   assign bus.uart_transmit = transmit_q;
   assign bus.uart_tx_byte  = tx_byte;
   assign bus.a_ack         = a_ack_q;
   assign bus.b_ack         = b_ack_q;

   // ---------------- RX FIFO ----------------
   // Pointers carry one extra wrap bit to tell full apart from empty.
   logic [AW:0] wp, rp;
   logic [7:0]  mem [DEPTH];
   logic        empty, full, push, pop;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop   = bus.rd_req && !empty;
   // A pop in the same cycle frees the slot that the push will use.
   assign push  = bus.uart_received && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp[AW-1:0]] <= bus.uart_rx_byte;
   end

   assign bus.rd_valid = !empty;
   assign bus.rd_byte  = mem[rp[AW-1:0]];

   // ---------------- RX status ----------------
   logic       overrun_q;
   logic [7:0] err_cnt;

   // A set or increment event beats clr in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_q <= 1'b0;
         err_cnt   <= 8'd0;
      end else begin
         if (bus.uart_received && full && !pop)
            overrun_q <= 1'b1;
         else if (bus.clr)
            overrun_q <= 1'b0;

         if (bus.uart_recv_error) begin
            if (bus.clr)
               err_cnt <= 8'd1;
            else if (err_cnt != 8'hFF)
               err_cnt <= err_cnt + 8'd1;
         end else if (bus.clr) begin
            err_cnt <= 8'd0;
         end
      end
   end

   assign bus.rx_overrun = overrun_q;
   assign bus.rx_err_cnt = err_cnt;

endmodule

// File: tb/tb_uart_io_arbiter.sv
// tb_uart_io_arbiter
//   Directed bench for uart_io_arbiter with a small UART model. The model
//   raises is_transmitting for 5 cycles per accepted transmit, and it can be
//   told to ignore one transmit. Inputs change on the falling edge and outputs
//   are sampled on the falling edge.
module tb_uart_io_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_io_arbiter_if ifc();

   uart_io_arbiter #(.RX_DEPTH_LOG2(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- UART model ----------------
   logic       ignore_en = 1'b0;
   logic       ignored;
   int         busy_left;
   int         tx_cnt = 0;
   logic [7:0] last_tx_byte;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_left <= 0;
         ignored   <= 1'b0;
      end else begin
         if (ifc.uart_transmit) begin
            tx_cnt       <= tx_cnt + 1;
            last_tx_byte <= ifc.uart_tx_byte;
            if (ignore_en && !ignored) ignored <= 1'b1;
            else                       busy_left <= 5;
         end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
         end
         if (!ignore_en) ignored <= 1'b0;
      end
   end
   assign ifc.uart_is_transmitting = (busy_left != 0);

   // ---------------- ack counters ----------------
   int a_acks = 0;
   int b_acks = 0;
   always @(negedge clk) begin
      if (ifc.a_ack) a_acks++;
      if (ifc.b_ack) b_acks++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   // Waits (bounded) on the falling edge until an ack is high.
   task automatic wait_ack(input string tag, output logic got_b);
      int n;
      n = 0;
      while (!(ifc.a_ack || ifc.b_ack) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_no_timeout"}, 32'(n < 200), 32'd1);
      got_b = ifc.b_ack;
   endtask

   logic       gb;
   int         t0, a0, b0;
   logic [7:0] exp_b;

   initial begin
      ifc.a_req = 0; ifc.b_req = 0; ifc.a_byte = 0; ifc.b_byte = 0;
      ifc.rd_req = 0; ifc.clr = 0;
      ifc.uart_received = 0; ifc.uart_rx_byte = 0; ifc.uart_recv_error = 0;

      // reset state
      tick(2);
      chk("rst_transmit", 32'(ifc.uart_transmit), 0);
      chk("rst_tx_byte",  32'(ifc.uart_tx_byte), 0);
      chk("rst_a_ack",    32'(ifc.a_ack), 0);
      chk("rst_b_ack",    32'(ifc.b_ack), 0);
      chk("rst_rd_valid", 32'(ifc.rd_valid), 0);
      chk("rst_overrun",  32'(ifc.rx_overrun), 0);
      chk("rst_err_cnt",  32'(ifc.rx_err_cnt), 0);
      rst = 1'b0;
      tick(1);

      // A alone sends 0x41
      t0 = tx_cnt; a0 = a_acks; b0 = b_acks;
      ifc.a_req = 1; ifc.a_byte = 8'h41;
      tick(1);
      chk("a_transmit_pulse", 32'(ifc.uart_transmit), 1);
      chk("a_tx_byte",        32'(ifc.uart_tx_byte), 32'h41);
      tick(1);
      chk("a_transmit_one_cycle", 32'(ifc.uart_transmit), 0);
      wait_ack("a_alone", gb);
      chk("a_alone_is_a", 32'(gb), 0);
      ifc.a_req = 0;
      tick(1);
      chk("a_ack_one_cycle", 32'(ifc.a_ack), 0);
      tick(3);
      chk("a_alone_tx_cnt", 32'(tx_cnt - t0), 1);
      chk("a_alone_a_acks", 32'(a_acks - a0), 1);
      chk("a_alone_b_acks", 32'(b_acks - b0), 0);

      // both held after reset: A, B, A, B
      do_reset();
      ifc.a_req = 1; ifc.a_byte = 8'h11;
      ifc.b_req = 1; ifc.b_byte = 8'h22;
      for (int i = 0; i < 4; i++) begin
         wait_ack($sformatf("rr%0d", i), gb);
         exp_b = (i % 2 == 1) ? 8'h22 : 8'h11;
         chk($sformatf("rr%0d_grant_b", i), 32'(gb), 32'(i % 2));
         chk($sformatf("rr%0d_byte", i), 32'(last_tx_byte), 32'(exp_b));
         if (i == 3) begin
            ifc.a_req = 0; ifc.b_req = 0;
         end
         tick(1);
      end

      // UART ignores the first transmit: reissue same byte, single ack
      tick(2);
      ignore_en = 1;
      t0 = tx_cnt; a0 = a_acks; b0 = b_acks;
      ifc.a_req = 1; ifc.a_byte = 8'h5A;
      tick(1);
      wait_ack("retry", gb);
      ifc.a_req = 0;
      tick(5);
      ignore_en = 0;
      chk("retry_tx_cnt",  32'(tx_cnt - t0), 2);
      chk("retry_byte",    32'(last_tx_byte), 32'h5A);
      chk("retry_a_acks",  32'(a_acks - a0), 1);
      chk("retry_b_acks",  32'(b_acks - b0), 0);

      // RX: 5 pushes into depth 4 -> overrun, pops 1..4
      for (int i = 1; i <= 5; i++) begin
         ifc.uart_received = 1; ifc.uart_rx_byte = 8'(i);
         tick(1);
      end
      ifc.uart_received = 0;
      chk("ovr_set", 32'(ifc.rx_overrun), 1);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("pop%0d_valid", i), 32'(ifc.rd_valid), 1);
         chk($sformatf("pop%0d_byte", i),  32'(ifc.rd_byte), 32'(i));
         ifc.rd_req = 1;
         tick(1);
         ifc.rd_req = 0;
      end
      chk("pop_empty", 32'(ifc.rd_valid), 0);
      ifc.rd_req = 1;                   // pop on empty is ignored
      tick(1);
      ifc.rd_req = 0;
      ifc.uart_received = 1; ifc.uart_rx_byte = 8'h77;
      tick(1);
      ifc.uart_received = 0;
      chk("empty_pop_ignored_byte", 32'(ifc.rd_byte), 32'h77);
      ifc.rd_req = 1;
      tick(1);
      ifc.rd_req = 0;
      ifc.clr = 1;
      tick(1);
      ifc.clr = 0;
      chk("ovr_cleared", 32'(ifc.rx_overrun), 0);

      // full + simultaneous push/pop -> no overrun
      for (int i = 0; i < 4; i++) begin
         ifc.uart_received = 1; ifc.uart_rx_byte = 8'(8'h10 + i);
         tick(1);
      end
      ifc.uart_rx_byte = 8'h14; ifc.rd_req = 1;
      tick(1);
      ifc.uart_received = 0; ifc.rd_req = 0;
      chk("full_pushpop_no_ovr", 32'(ifc.rx_overrun), 0);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("pp_pop%0d_byte", i), 32'(ifc.rd_byte), 32'(8'h10 + i));
         ifc.rd_req = 1;
         tick(1);
         ifc.rd_req = 0;
      end
      chk("pp_empty", 32'(ifc.rd_valid), 0);

      // framing errors: count, saturate, clr races
      ifc.uart_recv_error = 1;
      tick(10);
      ifc.uart_recv_error = 0;
      chk("err_cnt_10", 32'(ifc.rx_err_cnt), 10);
      ifc.uart_recv_error = 1;
      tick(290);
      ifc.uart_recv_error = 0;
      chk("err_cnt_sat", 32'(ifc.rx_err_cnt), 255);
      ifc.clr = 1; ifc.uart_recv_error = 1;
      tick(1);
      ifc.clr = 0; ifc.uart_recv_error = 0;
      chk("err_clr_race", 32'(ifc.rx_err_cnt), 1);
      ifc.clr = 1;
      tick(1);
      ifc.clr = 0;
      chk("err_clr", 32'(ifc.rx_err_cnt), 0);

      // reset during WAIT_DONE abandons the transfer
      a0 = a_acks;
      ifc.a_req = 1; ifc.a_byte = 8'h33;
      begin
         int n;
         n = 0;
         while (!ifc.uart_is_transmitting && n < 50) begin
            tick(1);
            n++;
         end
         chk("wd_busy_seen", 32'(n < 50), 1);
      end
      tick(1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_tx_byte",  32'(ifc.uart_tx_byte), 0);
      chk("async_rst_transmit", 32'(ifc.uart_transmit), 0);
      chk("async_rst_a_ack",    32'(ifc.a_ack), 0);
      ifc.a_req = 0;
      tick(2);
      rst = 1'b0;
      tick(10);
      chk("rst_no_ack", 32'(a_acks - a0), 0);
      ifc.a_req = 1; ifc.a_byte = 8'h44;
      tick(1);
      wait_ack("post_rst", gb);
      ifc.a_req = 0;
      tick(2);
      chk("post_rst_byte", 32'(last_tx_byte), 32'h44);
      chk("post_rst_acks", 32'(a_acks - a0), 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
